// File: rtl/axis1_pos_cmp.sv
// Single-axis quadrature position counter with filtered encoder inputs, an
// armed compare-match flag and a 4-register Avalon-MM slave.
module axis1_pos_cmp #(
  parameter int FILT_LEN = 3
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        chipselect,
  input  logic [1:0]  address,
  input  logic        write_n,
  input  logic [31:0] writedata,
  input  logic        enc_a,
  input  logic        enc_b,
  output logic [31:0] readdata,
  output logic        match_out
);

  localparam logic [3:0] FL = 4'(FILT_LEN);

  logic [1:0]  a_sync, b_sync;
  logic [1:0]  sync_ab, cand_ab, filt_ab;
  logic [3:0]  cnt;
  logic        init;
  logic        step_inc, step_dec, step_err;

  logic [31:0] pos, cmp;
  logic [2:0]  ctrl;   // {ARM, INV, EN}
  logic        match, qerr;

  // Gray-order phase index: 00,01,11,10 -> 0,1,2,3
  function automatic logic [1:0] phase(input logic [1:0] ab);
    return {ab[1], ab[1] ^ ab[0]};
  endfunction

  assign sync_ab = {a_sync[1], b_sync[1]};

  // Candidate must sit unchanged for FL samples before it replaces filt_ab.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_sync   <= '0;
      b_sync   <= '0;
      cand_ab  <= '0;
      filt_ab  <= '0;
      cnt      <= '0;
      init     <= 1'b1;
      step_inc <= 1'b0;
      step_dec <= 1'b0;
      step_err <= 1'b0;
    end else begin
      a_sync   <= {a_sync[0], enc_a};
      b_sync   <= {b_sync[0], enc_b};
      step_inc <= 1'b0;
      step_dec <= 1'b0;
      step_err <= 1'b0;
      if (sync_ab != cand_ab) begin
        cand_ab <= sync_ab;
        cnt     <= 4'd1;
      end else begin
        if (cnt < FL) cnt <= cnt + 4'd1;
        if (cnt == FL && (init || cand_ab != filt_ab)) begin
          filt_ab <= cand_ab;
          init    <= 1'b0;
          if (!init) begin
            case (2'(phase(cand_ab) - phase(filt_ab)))
              2'd1:    step_inc <= 1'b1;
              2'd3:    step_dec <= 1'b1;
              2'd2:    step_err <= 1'b1;
              default: ;
            endcase
          end
        end
      end
    end
  end

  logic        wr, wr_pos, wr_cmp, wr_ctrl, wr_stat;
  logic        step_vld, hit;
  logic [31:0] pos_step;

  assign wr      = chipselect & ~write_n;
  assign wr_pos  = wr && address == 2'd0;
  assign wr_cmp  = wr && address == 2'd1;
  assign wr_ctrl = wr && address == 2'd2;
  assign wr_stat = wr && address == 2'd3;

  assign step_vld = (step_inc | step_dec) & ctrl[0];
  assign pos_step = (step_inc ^ ctrl[1]) ? pos + 32'd1 : pos - 32'd1;
  // Only a step that actually lands in POS can match; CPU writes never do.
  assign hit      = step_vld && ctrl[2] && !wr_pos && pos_step == cmp;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pos      <= '0;
      cmp      <= '0;
      ctrl     <= '0;
      match    <= 1'b0;
      qerr     <= 1'b0;
      readdata <= '0;
    end else begin
      if (wr_pos)        pos <= writedata;
      else if (step_vld) pos <= pos_step;

      if (wr_cmp) cmp <= writedata;

      if (wr_ctrl)  ctrl    <= writedata[2:0];
      else if (hit) ctrl[2] <= 1'b0;

      if (hit)          match <= 1'b1;
      else if (wr_stat) match <= 1'b0;

      if (step_err)     qerr <= 1'b1;
      else if (wr_stat) qerr <= 1'b0;

      case (address)
        2'd0:    readdata <= pos;
        2'd1:    readdata <= cmp;
        2'd2:    readdata <= {29'd0, ctrl};
        default: readdata <= {30'd0, qerr, match};
      endcase
    end
  end

  assign match_out = match;

endmodule

// File: doc/axis1_pos_cmp.md
AXIS1_POS_CMP -- requirements
Module: axis1_pos_cmp

Interface
REQ-001 SHALL have parameter FILT_LEN, default 3: consecutive clocks a synchronized encoder input must hold a new value before it is accepted (legal 1..15).
REQ-002 SHALL have port clk, input, 1: system clock, all logic rising-edge.
REQ-003 SHALL have port reset_n, input, 1: asynchronous active-low reset.
REQ-004 SHALL have port chipselect, input, 1: Avalon slave select.
REQ-005 SHALL have port address, input, 2: register index 0..3.
REQ-006 SHALL have port write_n, input, 1: active-low write strobe.
REQ-007 SHALL have port writedata, input, 32: write data.
REQ-008 SHALL have port enc_a, input, 1: asynchronous quadrature channel A.
REQ-009 SHALL have port enc_b, input, 1: asynchronous quadrature channel B.
REQ-010 SHALL have port readdata, output, 32: registered read data.
REQ-011 SHALL have port match_out, output, 1: compare-match level, drives axis interrupt PIO in_port.

Function
REQ-012 SHALL map registers: 0 POS (RW, signed 32-bit position), 1 CMP (RW, 32-bit compare), 2 CTRL (RW: bit0 EN count, bit1 INV direction, bit2 ARM), 3 STAT (R: bit0 MATCH, bit1 QERR; any write clears both).
REQ-013 SHALL register readdata one clock after address presented, independent of chipselect; unused bits read 0.
REQ-014 SHALL synchronize enc_a/enc_b through two flops each before filtering.
REQ-015 SHALL update filtered AB only when synchronized AB differs from filtered AB and has been identical for FILT_LEN consecutive clocks; any change restarts the count.
REQ-016 SHALL decode each filtered-AB change: 00->01->11->10->00 = +1, reverse = -1, both bits changed = no count and set QERR.
REQ-017 SHALL negate the step when INV=1, and apply no step when EN=0 (filtered AB still tracks).
REQ-018 SHALL update POS the clock after filtered AB changes; latency from first sync-stage sampling of a stable new level to POS update = FILT_LEN+3 clocks.
REQ-019 SHALL wrap POS modulo 2^32 (0x7FFFFFFF+1 = 0x80000000, 0x00000000-1 = 0xFFFFFFFF).
REQ-020 SHALL, when ARM=1 and the newly written POS value from a count step equals CMP, set MATCH and clear ARM in the same clock.
REQ-021 SHALL NOT raise a match from CPU writes to POS or CMP, even if they make POS==CMP.
REQ-022 SHALL drive match_out = MATCH (level, held until STAT written).
REQ-023 SHALL give a CPU POS write priority over a same-cycle count step (step discarded).
REQ-024 SHALL give a new match priority over a same-cycle STAT write (MATCH stays 1); same for QERR.
REQ-025 SHALL let a CPU write to CTRL with ARM=1 re-arm immediately; a same-cycle match-clear of ARM loses to the CPU write.
REQ-026 SHALL, on the first filter qualification after reset, load filtered AB from the inputs without counting or flagging QERR.

Reset
REQ-027 SHALL reset asynchronously: POS, CMP, CTRL, STAT, readdata, match_out, sync/filter state = 0, init flag set.
REQ-028 SHALL resume operation on the first clock after reset_n deasserts; reset mid-count discards in-flight filter progress.

Verification
REQ-029 Reset with AB=11, then 4 forward quadrature cycles (EN=1) -> POS=16, QERR=0.
REQ-030 POS=0x7FFFFFFF, one forward step -> POS=0x80000000; POS=0, INV=1, one forward step -> POS=0xFFFFFFFF.
REQ-031 Glitch on enc_a lasting FILT_LEN-1 clocks -> POS unchanged; stable edge -> POS updates exactly FILT_LEN+3 clocks after sampling.
REQ-032 CMP=5, ARM=1, forward from 0 -> match_out rises at step to 5, ARM reads 0, further steps past 5 and back do not re-match; STAT write -> match_out=0.
REQ-033 AB jump 00->11 -> POS unchanged, QERR=1; STAT write same cycle as new QERR -> QERR stays 1.
REQ-034 CPU write POS=100 same cycle as a count step -> POS=100.
